// File: rtl/ika2151_pkg.sv
// rtl/ika2151_pkg.sv - shared slot-count constants and types for the IKA2151 core
package ika2151_pkg;

    localparam int SLOTS_DEF = 32;
    localparam int CYCLE_W   = $clog2(SLOTS_DEF);

    typedef logic [CYCLE_W-1:0] cycle_t;

    function automatic logic is_last_slot(input cycle_t c);
        return c == cycle_t'(SLOTS_DEF - 1);
    endfunction

endpackage

// File: rtl/ika2151_cendiv.sv
// rtl/ika2151_cendiv.sv - divides a clock enable into rising/falling-edge enables
module ika2151_cendiv #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en_n,
    output logic o_pcen_n,
    output logic o_ncen_n
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] P_HALF = PW'(DIV / 2 - 1);

    logic          en;
    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;

    assign en = ~i_en_n;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = (p_q == P_LAST) ? '0 : p_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    // Gated by rst_n so both enables read deasserted the instant reset asserts.
    assign o_ncen_n = ~(rst_n & en & (p_q == P_HALF));
    assign o_pcen_n = ~(rst_n & en & (p_q == P_LAST));

endmodule

// File: rtl/ika2151_timinggen.sv
// rtl/ika2151_timinggen.sv - phi1 enables, slot counter and IC sync; IKA2151_IC_SYNC_EN selects 2-flop IC sync
module ika2151_timinggen
    import ika2151_pkg::*;
#(
    parameter int SLOTS    = SLOTS_DEF,
    parameter int PHIM_DIV = 2
) (
    input  logic                     i_EMUCLK,
    input  logic                     i_RST_n,
    input  logic                     i_phiM_PCEN_n,
    input  logic                     i_IC_n,
    output logic                     o_phi1_PCEN_n,
    output logic                     o_phi1_NCEN_n,
    output logic [$clog2(SLOTS)-1:0] o_CYCLE,
    output logic                     o_CYCLE_LAST,
    output logic                     o_CNTRRST,
    output logic                     o_IC_n
);

    localparam int CW = $clog2(SLOTS);
    localparam logic [CW-1:0] SLOT_LAST = CW'(SLOTS - 1);

    logic          pcen;
    logic          ic_q;
    logic          ic_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
`ifdef IKA2151_IC_SYNC_EN
    logic          ic_meta_q;
    logic          ic_meta_d;
`endif

    ika2151_cendiv #(
        .DIV(PHIM_DIV)
    ) u_cendiv (
        .clk      (i_EMUCLK),
        .rst_n    (i_RST_n),
        .i_en_n   (i_phiM_PCEN_n),
        .o_pcen_n (o_phi1_PCEN_n),
        .o_ncen_n (o_phi1_NCEN_n)
    );

    assign pcen = ~o_phi1_PCEN_n;

    always_comb begin
        ic_d  = ic_q;
        cnt_d = cnt_q;
`ifdef IKA2151_IC_SYNC_EN
        ic_meta_d = ic_meta_q;
`endif
        if (pcen) begin
`ifdef IKA2151_IC_SYNC_EN
            ic_meta_d = i_IC_n;
            ic_d      = ic_meta_q;
`else
            ic_d      = i_IC_n;
`endif
            // The load decision uses ic_q before this edge, so slot 0 follows IC release.
            if (!ic_q || cnt_q == SLOT_LAST) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            ic_q      <= 1'b0;
            cnt_q     <= '0;
`ifdef IKA2151_IC_SYNC_EN
            ic_meta_q <= 1'b0;
`endif
        end else begin
            ic_q      <= ic_d;
            cnt_q     <= cnt_d;
`ifdef IKA2151_IC_SYNC_EN
            ic_meta_q <= ic_meta_d;
`endif
        end
    end

    assign o_CYCLE      = cnt_q;
    assign o_CYCLE_LAST = (cnt_q == SLOT_LAST);
    assign o_CNTRRST    = (cnt_q == SLOT_LAST) & ic_q;
    assign o_IC_n       = ic_q;

endmodule

// File: tb/tb_ika2151_timinggen.sv
// tb/tb_ika2151_timinggen.sv - self-checking bench for ika2151_timinggen
module tb_ika2151_timinggen;

    localparam int DIV = 2;
    localparam int SL  = 32;
`ifdef IKA2151_IC_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, phim_n, ic_n_in;
    logic       pcen_n, ncen_n, last, cntrrst, ic_out;
    logic [4:0] cycle;
    logic       rst2_n, phim2_n, ic2_in;
    logic       pcen2_n, ncen2_n, last2, cntrrst2, ic2_out;
    logic [4:0] cycle2;

    always #5 clk = ~clk;

    ika2151_timinggen #(.SLOTS(SL), .PHIM_DIV(DIV)) dut (
        .i_EMUCLK(clk), .i_RST_n(rst_n), .i_phiM_PCEN_n(phim_n), .i_IC_n(ic_n_in),
        .o_phi1_PCEN_n(pcen_n), .o_phi1_NCEN_n(ncen_n), .o_CYCLE(cycle),
        .o_CYCLE_LAST(last), .o_CNTRRST(cntrrst), .o_IC_n(ic_out)
    );

    ika2151_timinggen #(.SLOTS(SL), .PHIM_DIV(4)) dut4 (
        .i_EMUCLK(clk), .i_RST_n(rst2_n), .i_phiM_PCEN_n(phim2_n), .i_IC_n(ic2_in),
        .o_phi1_PCEN_n(pcen2_n), .o_phi1_NCEN_n(ncen2_n), .o_CYCLE(cycle2),
        .o_CYCLE_LAST(last2), .o_CNTRRST(cntrrst2), .o_IC_n(ic2_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: enable count since reset, slot number, history of IC samples.
    int n_en, m_slot, cyc;
    bit m_ic;
    bit samples[$];
    bit obs_pcen, obs_ncen, exp_pcen, exp_ncen;

    task automatic model_reset();
        n_en = 0; m_slot = 0; m_ic = 1'b0;
        samples.delete();
    endtask

    // Entered and left at posedge+1; comb outputs captured just before the edge.
    task automatic step(input bit en_n, input bit ic);
        bit old_ic;
        phim_n = en_n; ic_n_in = ic;
        #4;
        obs_pcen = pcen_n; obs_ncen = ncen_n;
        exp_pcen = !(!en_n && (n_en % DIV) == DIV - 1);
        exp_ncen = !(!en_n && (n_en % DIV) == DIV / 2 - 1);
        @(posedge clk);
        if (!exp_pcen) begin
            old_ic = m_ic;
            samples.push_back(ic);
            if (samples.size() > 4) void'(samples.pop_front());
            m_ic = (samples.size() >= LAT) ? samples[samples.size() - LAT] : 1'b0;
            m_slot = old_ic ? (m_slot + 1) % SL : 0;
        end
        if (!en_n) n_en++;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; phim_n = 1'b0; ic_n_in = 1'b0;
        #1;
        checks++; if (pcen_n !== 1'b1) begin errors++; $display("FAIL rst_pcen got %b exp 1", pcen_n); end
        checks++; if (ncen_n !== 1'b1) begin errors++; $display("FAIL rst_ncen got %b exp 1", ncen_n); end
        checks++; if (cycle !== 5'd0) begin errors++; $display("FAIL rst_cycle got %0d exp 0", cycle); end
        checks++; if (ic_out !== 1'b0) begin errors++; $display("FAIL rst_ic got %b exp 0", ic_out); end
        checks++; if (cntrrst !== 1'b0 || last !== 1'b0) begin errors++; $display("FAIL rst_last got %b/%b exp 0/0", last, cntrrst); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_cen_div2();
        int n_t[$];
        int p_t[$];
        int t0;
        t0 = cyc;
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < 4; k++) begin
                step(k != 0, 1'b0);
                if (!obs_ncen) n_t.push_back(cyc - 1);
                if (!obs_pcen) p_t.push_back(cyc - 1);
            end
        end
        checks++; if (n_t.size() != 2) begin errors++; $display("FAIL div2_ncen_count got %0d exp 2", n_t.size()); end
        checks++; if (p_t.size() != 2) begin errors++; $display("FAIL div2_pcen_count got %0d exp 2", p_t.size()); end
        if (n_t.size() == 2 && p_t.size() == 2) begin
            checks++; if (n_t[0] != t0) begin errors++; $display("FAIL div2_ncen_first got %0d exp %0d", n_t[0], t0); end
            checks++; if (p_t[0] != t0 + 4) begin errors++; $display("FAIL div2_pcen_first got %0d exp %0d", p_t[0], t0 + 4); end
            checks++; if (n_t[1] - n_t[0] != 8) begin errors++; $display("FAIL div2_ncen_period got %0d exp 8", n_t[1] - n_t[0]); end
            checks++; if (p_t[1] - p_t[0] != 8) begin errors++; $display("FAIL div2_pcen_period got %0d exp 8", p_t[1] - p_t[0]); end
        end
    endtask

    task automatic test_slot_count();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step($urandom_range(0, 1) == 0, 1'b1);
            if (ic_out === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL slot_ic_release timeout got 0 exp 1"); end
        checks++; if (cycle !== 5'd0) begin errors++; $display("FAIL slot_first got %0d exp 0", cycle); end
        for (int i = 1; i <= 32; i++) begin
            found = 1'b0;
            for (int j = 0; j < 100 && !found; j++) begin
                step($urandom_range(0, 1) == 0, 1'b1);
                if (!obs_pcen) found = 1'b1;
            end
            checks++; if (!found || cycle !== 5'(i % SL)) begin errors++; $display("FAIL slot_seq got %0d exp %0d", cycle, i % SL); end
            checks++; if (last !== (i % SL == SL - 1) || cntrrst !== (i % SL == SL - 1)) begin
                errors++; $display("FAIL slot_last_rst got %b/%b exp %b", last, cntrrst, i % SL == SL - 1);
            end
        end
    endtask

    task automatic test_ic_assert();
        bit found;
        int npc;
        bit rst_seen;
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            step(1'b0, 1'b1);
            if (cycle === 5'd17 && !obs_pcen) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL ic_reach17 timeout got %0d exp 17", cycle); end
        npc = 0; found = 1'b0; rst_seen = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(1'b0, 1'b0);
            if (!obs_pcen) npc++;
            if (cntrrst) rst_seen = 1'b1;
            if (ic_out === 1'b0) found = 1'b1;
        end
        checks++; if (!found || npc != LAT) begin errors++; $display("FAIL ic_latency got %0d exp %0d", npc, LAT); end
        for (int p = 0; p < 6; p++) begin
            found = 1'b0;
            for (int j = 0; j < 20 && !found; j++) begin
                step(1'b0, 1'b0);
                if (cntrrst) rst_seen = 1'b1;
                if (!obs_pcen) found = 1'b1;
            end
            checks++; if (!found || cycle !== 5'd0) begin errors++; $display("FAIL ic_hold0 got %0d exp 0", cycle); end
        end
        checks++; if (rst_seen) begin errors++; $display("FAIL ic_cntrrst got 1 exp 0"); end
    endtask

    task automatic test_random();
        bit ic;
        ic = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) ic = ~ic;
            step($urandom_range(0, 2) != 0, ic);
            checks++; if (obs_pcen !== exp_pcen) begin errors++; $display("FAIL rnd_pcen got %b exp %b", obs_pcen, exp_pcen); end
            checks++; if (obs_ncen !== exp_ncen) begin errors++; $display("FAIL rnd_ncen got %b exp %b", obs_ncen, exp_ncen); end
            checks++; if (!obs_pcen && !obs_ncen) begin errors++; $display("FAIL rnd_overlap got 0/0 exp not both low"); end
            checks++; if (cycle !== 5'(m_slot)) begin errors++; $display("FAIL rnd_cycle got %0d exp %0d", cycle, m_slot); end
            checks++; if (ic_out !== m_ic) begin errors++; $display("FAIL rnd_ic got %b exp %b", ic_out, m_ic); end
            checks++; if (last !== (m_slot == SL - 1)) begin errors++; $display("FAIL rnd_last got %b exp %b", last, m_slot == SL - 1); end
            checks++; if (cntrrst !== (m_slot == SL - 1 && m_ic)) begin errors++; $display("FAIL rnd_cntrrst got %b exp %b", cntrrst, m_slot == SL - 1 && m_ic); end
        end
    endtask

    task automatic test_rst_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            step(1'b0, 1'b1);
            if (cycle === 5'd9 && ic_out === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach9 got %0d exp 9", cycle); end
        phim_n = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (pcen_n !== 1'b1 || ncen_n !== 1'b1) begin errors++; $display("FAIL rstmid_cen got %b/%b exp 1/1", pcen_n, ncen_n); end
        checks++; if (cycle !== 5'd0) begin errors++; $display("FAIL rstmid_cycle got %0d exp 0", cycle); end
        checks++; if (ic_out !== 1'b0) begin errors++; $display("FAIL rstmid_ic got %b exp 0", ic_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 1) == 0, 1'b1);
            checks++; if (cycle !== 5'(m_slot) || ic_out !== m_ic) begin
                errors++; $display("FAIL rstmid_after got %0d/%b exp %0d/%b", cycle, ic_out, m_slot, m_ic);
            end
        end
    endtask

    task automatic test_div4_held();
        @(posedge clk); #1;
        rst2_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            #4;
            checks++; if (ncen2_n !== ((k % 4 == 2) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL div4_ncen clk %0d got %b", k, ncen2_n); end
            checks++; if (pcen2_n !== ((k % 4 == 0) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL div4_pcen clk %0d got %b", k, pcen2_n); end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; phim_n = 1'b1; ic_n_in = 1'b0;
        rst2_n = 1'b0; phim2_n = 1'b0; ic2_in = 1'b1;
        cyc = 0;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_cen_div2();
        test_slot_count();
        test_ic_assert();
        test_random();
        test_rst_mid();
        test_div4_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ika2151_timinggen.md
# ika2151_timinggen

Master timing generator for the IKA2151 core. It sits directly upstream of every counter, shift-register and BRAM-delay cell. It divides the board-supplied phiM clock enable into the phi1 positive/negative edge enables (`PCEN_n`/`NCEN_n`) that those cells consume. It also runs the operator-slot cycle counter, and generates the shift-register pointer resynchronisation pulse and the synchronised initial-clear signal.

## Interface
Parameters:
- `SLOTS`, default 32: operator slots per sample loop; must be a power of two, 4 to 64.
- `PHIM_DIV`, default 2: phiM enables per phi1 period; must be even, at least 2.

Ports:
- `i_EMUCLK`, input, 1 bit: emulator master clock; the only clock.
- `i_RST_n`, input, 1 bit: reset, asynchronous, active-low.
- `i_phiM_PCEN_n`, input, 1 bit: phiM enable, active-low, one `i_EMUCLK` cycle wide; may be held low continuously.
- `i_IC_n`, input, 1 bit: chip initial clear, active-low, level.
- `o_phi1_PCEN_n`, output, 1 bit: phi1 rising-edge enable, active-low, one `i_EMUCLK` cycle wide.
- `o_phi1_NCEN_n`, output, 1 bit: phi1 falling-edge enable, active-low, one `i_EMUCLK` cycle wide.
- `o_CYCLE`, output, `$clog2(SLOTS)` bits: current operator slot.
- `o_CYCLE_LAST`, output, 1 bit: high while `o_CYCLE == SLOTS-1`.
- `o_CNTRRST`, output, 1 bit: pointer reset for BRAM delay lines; high during slot `SLOTS-1`.
- `o_IC_n`, output, 1 bit: synchronised initial clear, active-low.

## Operation
- Prescaler `p`, width `$clog2(PHIM_DIV)`:
  - increments on every cycle with `i_phiM_PCEN_n==0`;
  - wraps from `PHIM_DIV-1` to 0;
  - free-runs and is unaffected by IC.
- `o_phi1_NCEN_n = ~(~i_phiM_PCEN_n & p==PHIM_DIV/2-1)`. Combinational, zero latency.
- `o_phi1_PCEN_n = ~(~i_phiM_PCEN_n & p==PHIM_DIV-1)`. Combinational, zero latency.
- Consequence: PCEN and NCEN strictly alternate, are never low in the same cycle, and are each at most one cycle wide per phiM enable.
- IC path: `i_IC_n` is sampled only on phi1 PCEN cycles, giving `ic_q`; `o_IC_n = ic_q`, registered.
- Slot counter, updated on the PCEN cycle:
  - if `ic_q==0`, load 0;
  - otherwise increment, wrapping from `SLOTS-1` to 0.
- The load takes the value of `ic_q` before that edge. The first slot after IC release is therefore 0, then 1.
- `o_CYCLE_LAST` and `o_CNTRRST` decode the registered counter. `o_CNTRRST` is additionally forced 0 while `o_IC_n==0`.
- Downstream cells sampling `o_CNTRRST` on the same PCEN therefore reset their pointers as the counter wraps to 0.

## Timing
- Reset values (while `i_RST_n` is low, asynchronously):
  - `p=0`, counter 0;
  - IC sync stages 0, so `o_IC_n=0`;
  - `o_CNTRRST=0`, `o_CYCLE_LAST=0`;
  - both CEN outputs forced to 1 (deasserted).
- Reset released mid-period: the prescaler starts from 0. The first PCEN comes on the `PHIM_DIV`-th phiM enable.
- IC latency: `i_IC_n` change to `o_IC_n` change takes 2 PCEN edges with the macro, 1 without.
- IC asserted mid-loop: the counter reaches 0 on the PCEN after `o_IC_n` falls and holds 0 while it stays low. The loop is not completed.
- IC shorter than one phi1 period may be missed; this is not an error.
- `i_phiM_PCEN_n` held low: the phi1 period is `PHIM_DIV` `i_EMUCLK` cycles.
  - With `PHIM_DIV=2`, NCEN and PCEN alternate every cycle.

## Configuration
- `IKA2151_IC_SYNC_EN` defined: `i_IC_n` passes through two PCEN-enabled flops. This is metastability-safe for asynchronous sources. IC latency is 2 phi1 edges.
- Not defined: a single PCEN-enabled flop; `i_IC_n` must be synchronous to `i_EMUCLK`. IC latency is 1 phi1 edge.
- All other behaviour is identical with and without the macro.

## Structure
- Shared package `ika2151_pkg`:
  - `SLOTS` default constant;
  - `CYCLE_W = $clog2(SLOTS)`;
  - cycle-count typedef `cycle_t`, used by every slot-indexed block.
- One sub-module, `ika2151_cendiv`: the prescaler plus the combinational PCEN/NCEN decode. It is reusable for other divided enables.
- Slot counter and IC sync stay in the top level.

## Test plan
- Reset, then `PHIM_DIV=2` with a phiM enable every 4 clocks:
  - required: NCEN low at the 1st enable and PCEN low at the 2nd;
  - each exactly 1 clock wide, pulses 8 clocks apart.
- `i_IC_n` released, then 33 PCENs:
  - required: `o_CYCLE` reads 0, 1, …, 31, 0;
  - `o_CYCLE_LAST` and `o_CNTRRST` high only while in slot 31.
- `i_IC_n` low at slot 17, with macro:
  - required: `o_IC_n` falls after 2 PCENs, `o_CYCLE` becomes 0 at the next PCEN and holds;
  - `o_CNTRRST` stays 0 throughout.
- Same stimulus without the macro:
  - required: `o_IC_n` falls after 1 PCEN.
- `i_RST_n` pulsed between enables at slot 9:
  - required: CENs high, `o_CYCLE=0`, `o_IC_n=0` immediately, without waiting for a clock edge.
- `PHIM_DIV=4`, `i_phiM_PCEN_n` held low:
  - required: NCEN low at clock 2 mod 4 and PCEN low at clock 4 mod 4 (i.e. 0 mod 4), counting clocks from reset release;
  - period 4, never overlapping.
